// File: rtl/key_encoder_pkg.sv
// Shared definitions for the key encoder: TABLE_ENTRY layout, field limits, FSM states.
package key_encoder_pkg;

    localparam int ENTRY_W = 128;

    typedef logic [ENTRY_W-1:0] table_entry_t;

    // TABLE_ENTRY field slices
    localparam int FN_HI   = 127;
    localparam int FN_LO   = 96;
    localparam int TYPE_HI = 95;
    localparam int TYPE_LO = 88;
    localparam int WT_HI   = 90;
    localparam int WT_LO   = 88;
    localparam int OFF_HI  = 87;
    localparam int OFF_LO  = 72;
    localparam int SIZE_HI = 71;
    localparam int SIZE_LO = 64;
    localparam int BASE_HI = 63;
    localparam int BASE_LO = 0;

    // Largest field number whose key still fits a 32-bit varint
    localparam logic [31:0] MAX_FIELD_NUM = 32'h1FFF_FFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        ADDR = 2'd2
    } key_enc_state_t;

    function automatic logic field_num_legal(input logic [31:0] fn);
        return (fn != '0) && (fn <= MAX_FIELD_NUM);
    endfunction

endpackage

// File: rtl/key_encoder_varint_len.sv
// Number of 7-bit varint groups needed to encode a 32-bit key (1..5).
module varint_len (
    input  logic [31:0] key,
    output logic [2:0]  nbytes
);

    // Leading-one detect per 7-bit group, highest group first
    always_comb begin
        nbytes = 3'd1;
        if (key[31:28] != '0)
            nbytes = 3'd5;
        else if (key[27:21] != '0)
            nbytes = 3'd4;
        else if (key[20:14] != '0)
            nbytes = 3'd3;
        else if (key[13:7] != '0)
            nbytes = 3'd2;
    end

endmodule

// File: rtl/key_encoder.sv
// Pops TABLE_ENTRY records, emits the protobuf field key as varint bytes,
// then hands the payload address/size to the payload reader.
module key_encoder
    import key_encoder_pkg::*;
#(
    parameter int ADDR_W    = 64,
    parameter int KEY_BYTES = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ENTRY_W-1:0]  entry_in,
    input  logic                entry_valid,
    output logic                entry_ready,
    output logic [7:0]          out_byte,
    output logic                out_valid,
    output logic                out_last,
    input  logic                out_ready,
    output logic [ADDR_W-1:0]   field_addr,
    output logic [7:0]          field_size,
    output logic                field_valid,
    input  logic                field_ready,
    output logic                err
);

    localparam int CNT_W = $clog2(KEY_BYTES + 1);

    key_enc_state_t    state, state_nxt;
    logic              started_q;
    logic [31:0]       key_sh;
    logic [CNT_W-1:0]  remaining;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        size_q;
    logic              err_q;

    logic [31:0]       entry_fn;
    logic [31:0]       entry_key;
    logic [2:0]        entry_nbytes;
    logic              entry_legal;
    logic              accept;
    logic              unused_type_bits;

    assign entry_fn    = entry_in[FN_HI:FN_LO];
    assign entry_key   = {entry_fn[28:0], entry_in[WT_HI:WT_LO]};
    assign entry_legal = field_num_legal(entry_fn);
    assign accept      = entry_valid && entry_ready;
    assign err         = err_q;

    assign unused_type_bits = &{1'b0, entry_in[TYPE_HI:WT_HI+1]};

    varint_len u_varint_len (
        .key    (entry_key),
        .nbytes (entry_nbytes)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state and output decode; outputs are zero outside their own state
    always_comb begin
        state_nxt   = state;
        entry_ready = 1'b0;
        out_valid   = 1'b0;
        out_byte    = '0;
        out_last    = 1'b0;
        field_valid = 1'b0;
        field_addr  = '0;
        field_size  = '0;
        case (state)
            IDLE: begin
                entry_ready = started_q;
                if (entry_valid && started_q && entry_legal)
                    state_nxt = EMIT;
            end
            EMIT: begin
                out_valid = 1'b1;
                out_byte  = {(remaining > CNT_W'(1)), key_sh[6:0]};
                out_last  = (remaining == CNT_W'(1));
                if (out_ready && (remaining == CNT_W'(1)))
                    state_nxt = (size_q == '0) ? IDLE : ADDR;
            end
            ADDR: begin
                field_valid = 1'b1;
                field_addr  = addr_q;
                field_size  = size_q;
                if (field_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Entry capture, key shifting and error pulse; started_q holds off
    // entry_ready until the first edge after reset release
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            started_q <= 1'b0;
            key_sh    <= '0;
            remaining <= '0;
            addr_q    <= '0;
            size_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            started_q <= 1'b1;
            err_q     <= accept && !entry_legal;
            if (accept && entry_legal) begin
                key_sh    <= entry_key;
                remaining <= CNT_W'(entry_nbytes);
                addr_q    <= ADDR_W'(entry_in[BASE_HI:BASE_LO]) + ADDR_W'(entry_in[OFF_HI:OFF_LO]);
                size_q    <= entry_in[SIZE_HI:SIZE_LO];
            end else if (state == EMIT && out_ready) begin
                key_sh    <= key_sh >> 7;
                remaining <= remaining - CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_key_encoder.sv
// Directed bench for key_encoder with hand-computed varint keys and addresses.
module tb_key_encoder;

    logic         clk = 1'b0;
    logic         reset;
    logic [127:0] entry_in;
    logic         entry_valid;
    logic         entry_ready;
    logic [7:0]   out_byte;
    logic         out_valid;
    logic         out_last;
    logic         out_ready;
    logic [63:0]  field_addr;
    logic [7:0]   field_size;
    logic         field_valid;
    logic         field_ready;
    logic         err;

    int checks   = 0;
    int failures = 0;

    key_encoder #(.ADDR_W(64), .KEY_BYTES(5)) dut (
        .clk         (clk),
        .reset       (reset),
        .entry_in    (entry_in),
        .entry_valid (entry_valid),
        .entry_ready (entry_ready),
        .out_byte    (out_byte),
        .out_valid   (out_valid),
        .out_last    (out_last),
        .out_ready   (out_ready),
        .field_addr  (field_addr),
        .field_size  (field_size),
        .field_valid (field_valid),
        .field_ready (field_ready),
        .err         (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    function automatic logic [127:0] mk(input logic [31:0] fn, input logic [7:0] ty,
                                        input logic [15:0] off, input logic [7:0] sz,
                                        input logic [63:0] base);
        return {fn, ty, off, sz, base};
    endfunction

    // Present an entry and return #1 after the edge that accepts it
    task automatic push(input logic [127:0] e);
        int n;
        n = 0;
        entry_in    = e;
        entry_valid = 1'b1;
        while (!entry_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("push_ready", entry_ready, 1);
        @(posedge clk); #1;
        entry_valid = 1'b0;
    endtask

    // Drain one key, optionally toggling out_ready to exercise stalls
    task automatic expect_key(input logic [7:0] want [5], input int n, input bit toggle);
        int got;
        int cyc;
        got = 0;
        cyc = 0;
        while (got < n && cyc < 50) begin
            out_ready = toggle ? ~out_ready : 1'b1;
            check("key_valid", out_valid, 1);
            if (out_valid) begin
                check("key_byte", out_byte, want[got]);
                check("key_last", out_last, (got == n - 1));
                if (out_ready) got++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        out_ready = 1'b1;
        check("key_count", got, n);
        check("key_done", out_valid, 0);
    endtask

    task automatic expect_field(input logic [63:0] addr, input logic [7:0] sz, input bit stall);
        field_ready = !stall;
        check("fld_valid", field_valid, 1);
        check("fld_addr", field_addr, addr);
        check("fld_size", field_size, sz);
        if (stall) begin
            @(posedge clk); #1;
            check("fld_hold_valid", field_valid, 1);
            check("fld_hold_addr", field_addr, addr);
            field_ready = 1'b1;
        end
        @(posedge clk); #1;
        check("fld_done", field_valid, 0);
        check("fld_ready_back", entry_ready, 1);
    endtask

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset       = 1'b1;
        entry_in    = '0;
        entry_valid = 1'b0;
        out_ready   = 1'b1;
        field_ready = 1'b1;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_byte", out_byte, 0);
        check("rst_field_valid", field_valid, 0);
        check("rst_field_addr", field_addr, 0);
        check("rst_err", err, 0);
        check("rst_entry_ready", entry_ready, 0);
        #20;
        reset = 1'b0;
        #1;
        check("rel_ready_low", entry_ready, 0);
        @(posedge clk); #1;
        check("rel_ready_high", entry_ready, 1);

        // field 9, wire 0 -> 0x48; 0x1000 + 0x1800
        push(mk(32'd9, 8'h40, 16'h1800, 8'd8, 64'h1000));
        check("t1_ready_low", entry_ready, 0);
        expect_key('{8'h48, 8'h00, 8'h00, 8'h00, 8'h00}, 1, 1'b0);
        expect_field(64'h2800, 8'd8, 1'b0);

        // field 16, wire 2 -> 0x82 0x01; field handshake stalled one cycle
        push(mk(32'd16, 8'h02, 16'h0010, 8'd4, 64'h2000));
        expect_key('{8'h82, 8'h01, 8'h00, 8'h00, 8'h00}, 2, 1'b0);
        expect_field(64'h2010, 8'd4, 1'b1);

        // largest legal field number, wire 5, out_ready toggling
        push(mk(32'h1FFF_FFFF, 8'h05, 16'h0000, 8'h10, 64'h0));
        expect_key('{8'hFD, 8'hFF, 8'hFF, 8'hFF, 8'h0F}, 5, 1'b1);
        expect_field(64'h0, 8'h10, 1'b0);

        // field 0 dropped
        push(mk(32'd0, 8'h00, 16'h0000, 8'd4, 64'h100));
        check("fn0_err", err, 1);
        check("fn0_out_valid", out_valid, 0);
        check("fn0_ready", entry_ready, 1);
        @(posedge clk); #1;
        check("fn0_err_clear", err, 0);
        check("fn0_field_valid", field_valid, 0);
        check("fn0_out_valid2", out_valid, 0);

        // 2^29 is one past the legal range
        push(mk(32'h2000_0000, 8'h00, 16'h0000, 8'd4, 64'h100));
        check("fnbig_err", err, 1);
        check("fnbig_out_valid", out_valid, 0);
        @(posedge clk); #1;
        check("fnbig_err_clear", err, 0);

        // size 0: key only, straight back to IDLE
        push(mk(32'd1, 8'h00, 16'h0040, 8'd0, 64'h1234));
        expect_key('{8'h08, 8'h00, 8'h00, 8'h00, 8'h00}, 1, 1'b0);
        check("sz0_no_field", field_valid, 0);
        check("sz0_ready", entry_ready, 1);

        // address wraps modulo 2^64
        push(mk(32'd3, 8'h01, 16'h0020, 8'd1, 64'hFFFF_FFFF_FFFF_FFF0));
        expect_key('{8'h19, 8'h00, 8'h00, 8'h00, 8'h00}, 1, 1'b0);
        expect_field(64'h10, 8'd1, 1'b0);

        // reset during the second byte of field 16
        push(mk(32'd16, 8'h02, 16'h0010, 8'd4, 64'h2000));
        check("mid_b0", out_byte, 8'h82);
        @(posedge clk); #1;
        check("mid_b1", out_byte, 8'h01);
        reset = 1'b1;
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_out_byte", out_byte, 0);
        check("mid_rst_out_last", out_last, 0);
        check("mid_rst_field_valid", field_valid, 0);
        check("mid_rst_entry_ready", entry_ready, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        check("mid_rel_ready_low", entry_ready, 0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("mid_no_stale", out_valid, 0);
            check("mid_no_field", field_valid, 0);
        end
        check("mid_ready", entry_ready, 1);

        // normal operation resumes
        push(mk(32'd16, 8'h02, 16'h0010, 8'd4, 64'h3000));
        expect_key('{8'h82, 8'h01, 8'h00, 8'h00, 8'h00}, 2, 1'b0);
        expect_field(64'h3010, 8'd4, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
